seletor_de_usuario: RTL and testbench
=====================================

# seletor_de_usuario

Session controller that sits directly upstream of the user-type 7-segment display decoder and produces its `User[2:0]` and `Enable` inputs. It latches a 3-bit user code from switches on a Confirm press and holds the session until Logout. Invalid codes are shown for a fixed hold time, then cleared. An optional inactivity timeout can also end the session.

## Interface
- `INVALID_HOLD`, default 8: number of cycles an invalid code stays on the display (≥1).
- `TIMEOUT_CYCLES`, default 32: inactivity limit in ACTIVE, in cycles (≥1); used only with the macro.
- `CNT_W`, default 16: width of the shared down-counter; must hold max(INVALID_HOLD, TIMEOUT_CYCLES).
- `Clock`  in  1  system clock; all state changes on the rising edge.
- `Reset_n`  in  1  reset, asynchronous, active-low.
- `Code`  in  3  user code from switches; synchronous, stable.
- `Confirm`  in  1  debounced, synchronous button level, active-high.
- `Logout`  in  1  debounced, synchronous level, active-high.
- `User`  out  3  registered code to the display decoder.
- `Enable`  out  1  registered display enable (1 = show `User`).
- `Locked`  out  1  registered; 1 while an invalid code is being held.

## Operation
- Code classes:
  - valid = 001 U, 011 T, 101 A, 110 G, 111 P;
  - invalid = 010, 100;
  - neutral = 000.
- Confirm edge = `Confirm` & ~`Confirm_q`. `Confirm_q` is a register that resets to 1, so a level already high at reset release is not an edge.
- States: IDLE, ACTIVE, INVALID. All outputs are registered and decoded from state plus the latched code.
- IDLE: `User`=000, `Enable`=0, `Locked`=0.
  - Edge with valid code → ACTIVE, latch `Code`.
  - Edge with invalid code → INVALID, latch `Code`, counter=INVALID_HOLD-1.
  - Edge with 000, or no edge → stay.
- ACTIVE: `User`=latched code, `Enable`=1, `Locked`=0.
  - `Logout`=1 → IDLE. Logout has priority over a simultaneous edge.
  - Else edge with valid code → stay in ACTIVE, re-latch (direct user switch).
  - Edge with invalid code → INVALID.
  - Edge with 000 → IDLE.
- INVALID: `User`=latched invalid code, `Enable`=1, `Locked`=1.
  - Confirm edges are ignored.
  - `Logout`=1 → IDLE.
  - Else counter decrements each cycle; at 0 → IDLE.
- `Logout` in IDLE has no effect.
- Arithmetic: the counter is unsigned `CNT_W` bits, saturates at 0 and never wraps.
- Reset mid-operation: any state → IDLE asynchronously, the counter is cleared, and the latched code is set to 000.

## Timing
- Reset values: `User`=000, `Enable`=0, `Locked`=0, state=IDLE, counter=0, `Confirm_q`=1.
- Latency: `Confirm` sampled high at edge k (low at k-1) → new outputs are visible after edge k. This is one register stage; no combinational path from input to output.
- `Logout` sampled high at edge k → `Enable`=0, `User`=000 after edge k.
- INVALID: `Enable`=1 and `Locked`=1 for exactly INVALID_HOLD cycles, then IDLE outputs.
- Holding `Confirm` high produces one edge only. A new edge requires `Confirm` low for ≥1 cycle.
- `Code` is sampled only in the cycle of the Confirm edge; later `Code` changes are ignored.

## Configuration
- `SELETOR_TIMEOUT_EN` defined:
  - The counter is loaded with TIMEOUT_CYCLES-1 on entry to ACTIVE and on every accepted edge in ACTIVE.
  - It decrements every ACTIVE cycle; reaching 0 with no edge or `Logout` in that cycle → IDLE.
  - An ACTIVE session therefore lasts exactly TIMEOUT_CYCLES cycles after the last confirm.
- Not defined: no timeout logic is compiled. ACTIVE persists until `Logout` or a Confirm edge, and the counter serves INVALID only.

## Test plan
- Reset: assert `Reset_n`=0 mid-ACTIVE with `User`=101 → `User`=000, `Enable`=0, `Locked`=0 immediately, before the next clock. Release with `Confirm` held high → stays IDLE.
- Valid login:
  - `Code`=011, one-cycle `Confirm` pulse → after the next edge `User`=011, `Enable`=1.
  - Change `Code` to 110 without a pulse → `User` stays 011.
- Direct switch and logout:
  - In ACTIVE (001), pulse with `Code`=111 → `User`=111.
  - Assert `Logout` and a Confirm edge in the same cycle → `User`=000, `Enable`=0.
- Invalid hold:
  - `Code`=100, pulse → `User`=100, `Enable`=1, `Locked`=1 for exactly 8 cycles, then `User`=000, `Enable`=0.
  - A pulse during the hold is ignored.
- Held button: `Confirm` high for 20 cycles with `Code` changing 001→101 → only 001 latched.
- Timeout (with `SELETOR_TIMEOUT_EN`):
  - Login 101, then no input → `Enable` drops after exactly 32 cycles.
  - A re-confirm at cycle 20 extends the session to 20+32.
  - Without the macro, `Enable` stays 1 for 100+ cycles.

Source files
------------

// File: rtl/seletor_de_usuario_if.sv
// Bundle between the session controller and whatever drives/consumes it:
// switch code, Confirm/Logout levels in; display code, enable and lock flag out.
interface seletor_de_usuario_if;
  logic [2:0] Code;
  logic       Confirm;
  logic       Logout;
  logic [2:0] User;
  logic       Enable;
  logic       Locked;

  // Driver side: switches and buttons, observes the display signals.
  modport master (
    output Code, Confirm, Logout,
    input  User, Enable, Locked
  );

  // Controller side.
  modport slave (
    input  Code, Confirm, Logout,
    output User, Enable, Locked
  );
endinterface

// File: rtl/seletor_de_usuario.sv
// Session controller feeding the user-type 7-segment decoder.
// Latches a user code on a Confirm rising edge, holds the session until
// Logout, shows invalid codes for INVALID_HOLD cycles before clearing.
// Optional inactivity timeout: define SELETOR_TIMEOUT_EN.
module seletor_de_usuario #(
  parameter int unsigned INVALID_HOLD   = 8,
  parameter int unsigned TIMEOUT_CYCLES = 32,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                 Clock,
  input  logic                 Reset_n,
  seletor_de_usuario_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACTIVE  = 2'd1,
    S_INVALID = 2'd2
  } state_t;

  localparam int unsigned CNT_NEED =
    (INVALID_HOLD > TIMEOUT_CYCLES) ? INVALID_HOLD : TIMEOUT_CYCLES;

  // Refuse to elaborate with a counter too narrow for the longest load value.
  if ((CNT_NEED - 1) >= (64'd1 << CNT_W)) begin : g_cnt_w_check
    $error("seletor_de_usuario: CNT_W too small for INVALID_HOLD/TIMEOUT_CYCLES");
  end

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(INVALID_HOLD - 1);
`ifdef SELETOR_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

  state_t           state_q, state_d;
  logic [2:0]       code_q, code_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             confirm_q;
  logic             confirm_edge;
  logic [2:0]       user_q, user_d;
  logic             enable_q, enable_d;
  logic             locked_q, locked_d;

  function automatic logic is_valid(input logic [2:0] c);
    return (c == 3'b001) || (c == 3'b011) || (c == 3'b101) ||
           (c == 3'b110) || (c == 3'b111);
  endfunction

  function automatic logic is_invalid(input logic [2:0] c);
    return (c == 3'b010) || (c == 3'b100);
  endfunction

  // confirm_q resets high so a button already pressed at reset release is not an edge.
  assign confirm_edge = bus.Confirm & ~confirm_q;

  // Next-state, latched code and shared down-counter.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (confirm_edge) begin
          if (is_valid(bus.Code)) begin
            state_d = S_ACTIVE;
            code_d  = bus.Code;
`ifdef SELETOR_TIMEOUT_EN
            cnt_d   = TIMEOUT_LOAD;
`endif
          end else if (is_invalid(bus.Code)) begin
            state_d = S_INVALID;
            code_d  = bus.Code;
            cnt_d   = HOLD_LOAD;
          end
        end
      end
      S_ACTIVE: begin
        if (bus.Logout) begin
          state_d = S_IDLE;
          code_d  = 3'b000;
          cnt_d   = '0;
        end else if (confirm_edge) begin
          if (is_valid(bus.Code)) begin
            code_d  = bus.Code;
`ifdef SELETOR_TIMEOUT_EN
            cnt_d   = TIMEOUT_LOAD;
`endif
          end else if (is_invalid(bus.Code)) begin
            state_d = S_INVALID;
            code_d  = bus.Code;
            cnt_d   = HOLD_LOAD;
          end else begin
            state_d = S_IDLE;
            code_d  = 3'b000;
            cnt_d   = '0;
          end
        end else begin
`ifdef SELETOR_TIMEOUT_EN
          // Inactivity countdown; session ends in the cycle the counter is already 0.
          if (cnt_q == '0) begin
            state_d = S_IDLE;
            code_d  = 3'b000;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
`endif
        end
      end
      S_INVALID: begin
        // Confirm edges are deliberately ignored while the invalid code is shown.
        if (bus.Logout || (cnt_q == '0)) begin
          state_d = S_IDLE;
          code_d  = 3'b000;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        code_d  = 3'b000;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from the next state so the registered outputs line up with the state.
  always_comb begin
    user_d   = (state_d == S_IDLE) ? 3'b000 : code_d;
    enable_d = (state_d != S_IDLE);
    locked_d = (state_d == S_INVALID);
  end

  // State, code, counter, edge detector and output registers.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= S_IDLE;
      code_q    <= 3'b000;
      cnt_q     <= '0;
      confirm_q <= 1'b1;
      user_q    <= 3'b000;
      enable_q  <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      cnt_q     <= cnt_d;
      confirm_q <= bus.Confirm;
      user_q    <= user_d;
      enable_q  <= enable_d;
      locked_q  <= locked_d;
    end
  end

  assign bus.User   = user_q;
  assign bus.Enable = enable_q;
  assign bus.Locked = locked_q;

endmodule

// File: tb/tb_seletor_de_usuario.sv
// Directed bench for seletor_de_usuario with default parameters.
// Define SELETOR_TIMEOUT_EN on both RTL and bench to exercise the timeout.
module tb_seletor_de_usuario;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  seletor_de_usuario_if bus ();

  seletor_de_usuario #(
    .INVALID_HOLD   (8),
    .TIMEOUT_CYCLES (32),
    .CNT_W          (16)
  ) dut (
    .Clock   (clk),
    .Reset_n (rst_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; inputs are driven and outputs sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] obs();
    return {bus.User, bus.Enable, bus.Locked};
  endfunction

  task automatic test_reset();
    logic [4:0] o;
    rst_n = 1'b1; bus.Code = 3'b000; bus.Confirm = 1'b0; bus.Logout = 1'b0;
    #1 rst_n = 1'b0;
    #1 o = obs(); total++;
    if (o !== 5'b000_0_0) begin bad++; $display("FAIL reset_initial: got %b expected %b", o, 5'b000_0_0); end
    step(); step();
    rst_n = 1'b1;
    step();
    o = obs(); total++;
    if (o !== 5'b000_0_0) begin bad++; $display("FAIL reset_release_idle: got %b expected %b", o, 5'b000_0_0); end
    // Log in as 101, then reset mid-session.
    bus.Code = 3'b101; bus.Confirm = 1'b1; step(); bus.Confirm = 1'b0;
    o = obs(); total++;
    if (o !== 5'b101_1_0) begin bad++; $display("FAIL reset_login101: got %b expected %b", o, 5'b101_1_0); end
    step();
    #1 rst_n = 1'b0;
    #1 o = obs(); total++;
    if (o !== 5'b000_0_0) begin bad++; $display("FAIL reset_async_clear: got %b expected %b", o, 5'b000_0_0); end
    bus.Confirm = 1'b1;
    #2 rst_n = 1'b1;
    step(); step();
    o = obs(); total++;
    if (o !== 5'b000_0_0) begin bad++; $display("FAIL reset_held_confirm: got %b expected %b", o, 5'b000_0_0); end
    bus.Confirm = 1'b0; step();
  endtask

  task automatic test_valid_login();
    logic [4:0] o;
    bus.Code = 3'b011; bus.Confirm = 1'b1; step(); bus.Confirm = 1'b0;
    o = obs(); total++;
    if (o !== 5'b011_1_0) begin bad++; $display("FAIL login011: got %b expected %b", o, 5'b011_1_0); end
    bus.Code = 3'b110; step(); step(); step();
    o = obs(); total++;
    if (o !== 5'b011_1_0) begin bad++; $display("FAIL code_change_no_pulse: got %b expected %b", o, 5'b011_1_0); end
  endtask

  task automatic test_switch_logout();
    logic [4:0] o;
    bus.Code = 3'b001; bus.Confirm = 1'b1; step(); bus.Confirm = 1'b0;
    o = obs(); total++;
    if (o !== 5'b001_1_0) begin bad++; $display("FAIL switch_to001: got %b expected %b", o, 5'b001_1_0); end
    step();
    bus.Code = 3'b111; bus.Confirm = 1'b1; step(); bus.Confirm = 1'b0;
    o = obs(); total++;
    if (o !== 5'b111_1_0) begin bad++; $display("FAIL switch_to111: got %b expected %b", o, 5'b111_1_0); end
    step();
    bus.Logout = 1'b1; bus.Code = 3'b101; bus.Confirm = 1'b1; step();
    o = obs(); total++;
    if (o !== 5'b000_0_0) begin bad++; $display("FAIL logout_priority: got %b expected %b", o, 5'b000_0_0); end
    bus.Logout = 1'b0; bus.Confirm = 1'b0; step();
    o = obs(); total++;
    if (o !== 5'b000_0_0) begin bad++; $display("FAIL after_logout_idle: got %b expected %b", o, 5'b000_0_0); end
    // Edge with the neutral code ends an active session.
    bus.Code = 3'b110; bus.Confirm = 1'b1; step(); bus.Confirm = 1'b0;
    o = obs(); total++;
    if (o !== 5'b110_1_0) begin bad++; $display("FAIL login110: got %b expected %b", o, 5'b110_1_0); end
    step();
    bus.Code = 3'b000; bus.Confirm = 1'b1; step(); bus.Confirm = 1'b0;
    o = obs(); total++;
    if (o !== 5'b000_0_0) begin bad++; $display("FAIL neutral_edge_exit: got %b expected %b", o, 5'b000_0_0); end
    step();
  endtask

  task automatic test_invalid_hold();
    logic [4:0] o;
    bus.Code = 3'b100; bus.Confirm = 1'b1; step();
    for (int i = 0; i < 8; i++) begin
      o = obs(); total++;
      if (o !== 5'b100_1_1) begin bad++; $display("FAIL invalid_hold_cycle%0d: got %b expected %b", i, o, 5'b100_1_1); end
      // A pulse with a valid code inside the hold must be ignored.
      if (i == 2) begin bus.Code = 3'b001; bus.Confirm = 1'b1; end
      else bus.Confirm = 1'b0;
      step();
    end
    o = obs(); total++;
    if (o !== 5'b000_0_0) begin bad++; $display("FAIL invalid_hold_end: got %b expected %b", o, 5'b000_0_0); end
    // Invalid code from an active session, then Logout cuts the hold short.
    bus.Code = 3'b001; bus.Confirm = 1'b1; step(); bus.Confirm = 1'b0; step();
    bus.Code = 3'b010; bus.Confirm = 1'b1; step(); bus.Confirm = 1'b0;
    o = obs(); total++;
    if (o !== 5'b010_1_1) begin bad++; $display("FAIL active_to_invalid010: got %b expected %b", o, 5'b010_1_1); end
    step();
    bus.Logout = 1'b1; step(); bus.Logout = 1'b0;
    o = obs(); total++;
    if (o !== 5'b000_0_0) begin bad++; $display("FAIL invalid_logout: got %b expected %b", o, 5'b000_0_0); end
    step();
  endtask

  task automatic test_held_button();
    logic [4:0] o;
    bus.Code = 3'b001; bus.Confirm = 1'b1; step();
    o = obs(); total++;
    if (o !== 5'b001_1_0) begin bad++; $display("FAIL held_first: got %b expected %b", o, 5'b001_1_0); end
    for (int i = 1; i < 20; i++) begin
      if (i == 5) bus.Code = 3'b101;
      step();
    end
    o = obs(); total++;
    if (o !== 5'b001_1_0) begin bad++; $display("FAIL held_no_relatch: got %b expected %b", o, 5'b001_1_0); end
    bus.Confirm = 1'b0; step();
    bus.Confirm = 1'b1; step(); bus.Confirm = 1'b0;
    o = obs(); total++;
    if (o !== 5'b101_1_0) begin bad++; $display("FAIL held_release_repress: got %b expected %b", o, 5'b101_1_0); end
    bus.Logout = 1'b1; step(); bus.Logout = 1'b0; step();
  endtask

`ifdef SELETOR_TIMEOUT_EN
  task automatic test_timeout();
    logic [4:0] o;
    bus.Code = 3'b101; bus.Confirm = 1'b1; step(); bus.Confirm = 1'b0;
    repeat (31) step();
    o = obs(); total++;
    if (o !== 5'b101_1_0) begin bad++; $display("FAIL timeout_cycle31: got %b expected %b", o, 5'b101_1_0); end
    step();
    o = obs(); total++;
    if (o !== 5'b000_0_0) begin bad++; $display("FAIL timeout_cycle32: got %b expected %b", o, 5'b000_0_0); end
    // Re-confirm at cycle 20 restarts the 32-cycle window.
    bus.Confirm = 1'b1; step(); bus.Confirm = 1'b0;
    repeat (19) step();
    bus.Confirm = 1'b1; step(); bus.Confirm = 1'b0;
    repeat (31) step();
    o = obs(); total++;
    if (o !== 5'b101_1_0) begin bad++; $display("FAIL timeout_extended_51: got %b expected %b", o, 5'b101_1_0); end
    step();
    o = obs(); total++;
    if (o !== 5'b000_0_0) begin bad++; $display("FAIL timeout_extended_52: got %b expected %b", o, 5'b000_0_0); end
  endtask
`else
  task automatic test_no_timeout();
    logic [4:0] o;
    int         high_cycles;
    high_cycles = 0;
    bus.Code = 3'b101; bus.Confirm = 1'b1; step(); bus.Confirm = 1'b0;
    for (int i = 0; i < 120; i++) begin
      if (bus.Enable === 1'b1) high_cycles++;
      step();
    end
    total++;
    if (high_cycles !== 120) begin bad++; $display("FAIL no_timeout_enable_cycles: got %0d expected %0d", high_cycles, 120); end
    o = obs(); total++;
    if (o !== 5'b101_1_0) begin bad++; $display("FAIL no_timeout_final: got %b expected %b", o, 5'b101_1_0); end
    bus.Logout = 1'b1; step(); bus.Logout = 1'b0; step();
  endtask
`endif

  initial begin
    test_reset();
    test_valid_login();
    test_switch_logout();
    test_invalid_hold();
    test_held_button();
`ifdef SELETOR_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
